// File: rtl/chunked_serial_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operands processed CHUNK bits per clock, LSB chunk first.
// start accepted in IDLE or DONE; busy for WIDTH/CHUNK cycles, then a one-cycle done pulse with results.
module chunked_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Cin_msb,
  output logic             V
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;

  logic [CHUNK-1:0] w_a_chk;
  logic [CHUNK-1:0] w_b_chk;
  logic [CHUNK:0]   w_sum;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_res;
  logic             w_last;
  int               w_base;

  always_comb begin
    w_base  = int'(r_cnt) * CHUNK;
    w_a_chk = r_a[w_base +: CHUNK];
    w_b_chk = r_b[w_base +: CHUNK];
    w_sum   = {1'b0, w_a_chk} + {1'b0, w_b_chk} + {{CHUNK{1'b0}}, r_carry};
    // Carry into the chunk MSB recovered from that bit's sum and operand bits.
    w_cmsb  = w_sum[CHUNK-1] ^ w_a_chk[CHUNK-1] ^ w_b_chk[CHUNK-1];
    w_res   = r_res;
    w_res[w_base +: CHUNK] = w_sum[CHUNK-1:0];
    w_last  = (r_cnt == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      S       <= '0;
      Cout    <= 1'b0;
      Cin_msb <= 1'b0;
      V       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_a     <= A;
            r_b     <= B ^ {WIDTH{SUB}};
            r_carry <= Cin ^ SUB;
            r_cnt   <= '0;
            r_res   <= '0;
            busy    <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_res   <= w_res;
          r_carry <= w_sum[CHUNK];
          r_cnt   <= r_cnt + CW'(1);
          if (w_last) begin
            S       <= w_res;
            Cout    <= w_sum[CHUNK];
            Cin_msb <= w_cmsb;
            V       <= w_sum[CHUNK] ^ w_cmsb;
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= ST_DONE;
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: 16/4 instance for most scenarios, 8/8 instance for the single-chunk case.
module tb_chunked_serial_adder;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        m;
    logic        v;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, cin, sub;
  logic [15:0] a, b;
  logic        busy, done, cout, cmsb, v;
  logic [15:0] s;

  logic        start8, cin8, sub8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, cout8, cmsb8, v8;
  logic [7:0]  s8;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];

  chunked_serial_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a), .B(b), .Cin(cin), .SUB(sub),
    .busy(busy), .done(done), .S(s), .Cout(cout), .Cin_msb(cmsb), .V(v)
  );

  chunked_serial_adder #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .A(a8), .B(b8), .Cin(cin8), .SUB(sub8),
    .busy(busy8), .done(done8), .S(s8), .Cout(cout8), .Cin_msb(cmsb8), .V(v8)
  );

  function automatic exp_t model16(input logic [15:0] ia, input logic [15:0] ib,
                                   input logic ci, input logic sb);
    exp_t        e;
    logic [15:0] bx;
    logic        c0;
    logic [16:0] full;
    logic [15:0] low;
    bx   = sb ? ~ib : ib;
    c0   = ci ^ sb;
    full = {1'b0, ia} + {1'b0, bx} + {16'd0, c0};
    low  = {1'b0, ia[14:0]} + {1'b0, bx[14:0]} + {15'd0, c0};
    e.s  = full[15:0];
    e.c  = full[16];
    e.m  = low[15];
    e.v  = full[16] ^ low[15];
    return e;
  endfunction

  // One operation on the 16-bit unit; optional mid-RUN start pulse with other operands.
  task automatic run_op(input logic [15:0] ia, input logic [15:0] ib, input logic ci,
                        input logic sb, input bit glitch, input string name);
    exp_t        e;
    int          cyc, bc;
    bit          seen, moved;
    logic [15:0] sprev;
    @(negedge clk);
    a = ia; b = ib; cin = ci; sub = sb; start = 1'b1;
    sbq.push_back(model16(ia, ib, ci, sb));
    sprev = s;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = ~ci; sub = ~sb;
    cyc = 1; bc = 0; seen = 0; moved = 0;
    while (cyc < 20) begin
      if (glitch && cyc == 2) begin
        start = 1'b1; a = 16'hAAAA; b = 16'h5555;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) bc++;
      if (s !== sprev) moved = 1;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done within %0d cycles", name, cyc);
    end
    total++;
    if (cyc !== 5) begin
      bad++; $display("FAIL %s latency: got %0d need 5", name, cyc);
    end
    total++;
    if (bc !== 4) begin
      bad++; $display("FAIL %s busy_cycles: got %0d need 4", name, bc);
    end
    total++;
    if (moved) begin
      bad++; $display("FAIL %s S_stable: S changed during RUN (prev %h)", name, sprev);
    end
    e = sbq.pop_front();
    total++;
    if (s !== e.s) begin
      bad++; $display("FAIL %s S: got %h need %h", name, s, e.s);
    end
    total++;
    if (cout !== e.c) begin
      bad++; $display("FAIL %s Cout: got %b need %b", name, cout, e.c);
    end
    total++;
    if (cmsb !== e.m) begin
      bad++; $display("FAIL %s Cin_msb: got %b need %b", name, cmsb, e.m);
    end
    total++;
    if (v !== e.v) begin
      bad++; $display("FAIL %s V: got %b need %b", name, v, e.v);
    end
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL %s busy_in_done: got %b need 0", name, busy);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b0) begin
      bad++; $display("FAIL %s done_pulse_width: got %b need 0", name, done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    #12;
    total++;
    if ({busy, done, s, cout, cmsb, v} !== 21'd0) begin
      bad++; $display("FAIL reset16: got %h need 0", {busy, done, s, cout, cmsb, v});
    end
    total++;
    if ({busy8, done8, s8, cout8, cmsb8, v8} !== 13'd0) begin
      bad++; $display("FAIL reset8: got %h need 0", {busy8, done8, s8, cout8, cmsb8, v8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0, "add_plain");
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_wrap");
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, "add_ovf");
    run_op(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 1'b0, "add_cin");
  endtask

  task automatic test_sub();
    run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, "sub_borrow");
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, "sub_ovf");
    run_op(16'h1000, 16'h0FFF, 1'b1, 1'b1, 1'b0, "sub_cin");
  endtask

  task automatic test_ignore_start();
    run_op(16'h0101, 16'h2020, 1'b0, 1'b0, 1'b1, "midrun_start");
  endtask

  task automatic test_back_to_back();
    logic [15:0] opa [3];
    logic [15:0] opb [3];
    exp_t e;
    int   cyc, last, ndone;
    bit   pend;
    opa[0] = 16'h1111; opb[0] = 16'h2222;
    opa[1] = 16'hF000; opb[1] = 16'h1001;
    opa[2] = 16'h7FFF; opb[2] = 16'h7FFF;
    @(negedge clk);
    a = opa[0]; b = opb[0]; cin = 1'b0; sub = 1'b0; start = 1'b1;
    sbq.push_back(model16(opa[0], opb[0], 1'b0, 1'b0));
    @(posedge clk);
    @(negedge clk);
    a = opa[1]; b = opb[1];
    sbq.push_back(model16(opa[1], opb[1], 1'b0, 1'b0));
    cyc = 1; last = 0; ndone = 0; pend = 0;
    while (ndone < 3 && cyc < 60) begin
      if (pend) begin
        pend = 0;
        if (ndone == 1) begin
          a = opa[2]; b = opb[2];
          sbq.push_back(model16(opa[2], opb[2], 1'b0, 1'b0));
        end else begin
          start = 1'b0;
        end
      end
      if (done) begin
        e = sbq.pop_front();
        total++;
        if (s !== e.s || cout !== e.c || cmsb !== e.m || v !== e.v) begin
          bad++;
          $display("FAIL b2b_result%0d: got S=%h C=%b M=%b V=%b need S=%h C=%b M=%b V=%b",
                   ndone, s, cout, cmsb, v, e.s, e.c, e.m, e.v);
        end
        if (ndone > 0) begin
          total++;
          if (cyc - last !== 5) begin
            bad++; $display("FAIL b2b_period%0d: got %0d need 5", ndone, cyc - last);
          end
        end
        last = cyc;
        ndone++;
        pend = 1;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++;
    if (ndone !== 3) begin
      bad++; $display("FAIL b2b_count: got %0d done pulses need 3", ndone);
    end
    repeat (6) @(negedge clk);
    sbq.delete();
  endtask

  task automatic test_reset_midrun();
    int  cyc;
    bit  spurious;
    @(negedge clk);
    a = 16'h1234; b = 16'h0001; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, s, cout, cmsb, v} !== 21'd0) begin
      bad++; $display("FAIL reset_midrun: got %h need 0", {busy, done, s, cout, cmsb, v});
    end
    @(negedge clk);
    rst_n = 1'b1;
    spurious = 0;
    for (cyc = 0; cyc < 8; cyc++) begin
      if (done || busy) spurious = 1;
      @(negedge clk);
    end
    total++;
    if (spurious) begin
      bad++; $display("FAIL reset_no_done: got activity after reset need none");
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_degenerate();
    exp_t e;
    int   cyc, bc;
    bit   seen;
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    e.s = 16'h0000; e.c = 1'b1; e.m = 1'b0; e.v = 1'b1;
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h01; b8 = 8'h02;
    cyc = 1; bc = 0; seen = 0;
    while (cyc < 10) begin
      if (done8) begin
        seen = 1;
        break;
      end
      if (busy8) bc++;
      @(negedge clk);
      cyc++;
    end
    total++;
    if (!seen || cyc !== 2) begin
      bad++; $display("FAIL w8_latency: got %0d seen=%0d need 2", cyc, seen);
    end
    total++;
    if (bc !== 1) begin
      bad++; $display("FAIL w8_busy: got %0d need 1", bc);
    end
    e = sbq.pop_front();
    total++;
    if (s8 !== e.s[7:0] || cout8 !== e.c || cmsb8 !== e.m || v8 !== e.v) begin
      bad++;
      $display("FAIL w8_result: got S=%h C=%b M=%b V=%b need S=%h C=%b M=%b V=%b",
               s8, cout8, cmsb8, v8, e.s[7:0], e.c, e.m, e.v);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
